// File: rtl/mole_spawner.sv
// Whack-a-mole spawner: picks a pseudo-random hole and exposes a mole there for a
// shrinking time window. It scores detector hits, counts misses and ends the game.
module mole_spawner #(
  parameter int          NUM_HOLES    = 18,
  parameter int          GAP_TICKS    = 25000000,
  parameter int          UP_TICKS     = 50000000,
  parameter int          MIN_UP_TICKS = 12500000,
  parameter int          STEP_TICKS   = 2500000,
  parameter int          MAX_MISSES   = 5,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 hit,
  output logic [4:0]           mole_position,
  output logic                 mole_valid,
  output logic [NUM_HOLES-1:0] mole_leds,
  output logic [7:0]           miss_count,
  output logic [7:0]           hit_total,
  output logic                 game_over,
  output logic [31:0]          up_ticks
);

  typedef enum logic [1:0] {IDLE, GAP, UP, OVER} state_t;

  localparam logic [15:0] SEED         = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [4:0]  NH           = 5'(NUM_HOLES);
  localparam logic [4:0]  NH_M1        = 5'(NUM_HOLES - 1);
  localparam logic [31:0] GAP_LOAD     = 32'(GAP_TICKS - 1);
  localparam logic [31:0] UP_INIT      = 32'(UP_TICKS);
  localparam logic [31:0] UP_MIN       = 32'(MIN_UP_TICKS);
  localparam logic [31:0] UP_STEP      = 32'(STEP_TICKS);
  localparam logic [32:0] SHRINK_FLOOR = {1'b0, UP_MIN} + {1'b0, UP_STEP};
  localparam logic [7:0]  MISS_LIMIT   = 8'(MAX_MISSES);
  localparam logic [NUM_HOLES-1:0] LED_ONE = {{(NUM_HOLES-1){1'b0}}, 1'b1};

  state_t      state, state_n;
  logic [31:0] timer, timer_n;
  logic [31:0] up_n;
  logic [15:0] lfsr, lfsr_n;
  logic [4:0]  pos_n, cand, next_pos;
  logic [7:0]  miss_n, hits_n;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Exposure shrinks by one step but never drops below the floor; compared
  // against floor+step so the subtraction can never wrap.
  function automatic logic [31:0] shrink_up(input logic [31:0] v);
    return ({1'b0, v} >= SHRINK_FLOOR) ? v - UP_STEP : UP_MIN;
  endfunction

  assign lfsr_n = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  // Reduce the 5-bit random value into range, then step off the previous hole.
  always_comb begin
    cand     = lfsr[4:0] % NH;
    next_pos = cand;
    if (cand == mole_position)
      next_pos = (cand == NH_M1) ? 5'd0 : cand + 5'd1;
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    pos_n   = mole_position;
    miss_n  = miss_count;
    hits_n  = hit_total;
    up_n    = up_ticks;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = GAP;
          timer_n = GAP_LOAD;
        end
      end
      GAP: begin
        if (timer == 32'd0) begin
          state_n = UP;
          pos_n   = next_pos;
          timer_n = up_ticks - 32'd1;
        end else begin
          timer_n = timer - 32'd1;
        end
      end
      UP: begin
        if (hit) begin
          hits_n  = sat_inc8(hit_total);
          up_n    = shrink_up(up_ticks);
          state_n = GAP;
          timer_n = GAP_LOAD;
        end else if (timer == 32'd0) begin
          miss_n  = miss_count + 8'd1;
          timer_n = GAP_LOAD;
          state_n = (miss_count + 8'd1 == MISS_LIMIT) ? OVER : GAP;
        end else begin
          timer_n = timer - 32'd1;
        end
      end
      OVER: begin
        if (start) begin
          miss_n  = 8'd0;
          hits_n  = 8'd0;
          up_n    = UP_INIT;
          state_n = GAP;
          timer_n = GAP_LOAD;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= 32'd0;
      lfsr          <= SEED;
      mole_position <= 5'd0;
      miss_count    <= 8'd0;
      hit_total     <= 8'd0;
      up_ticks      <= UP_INIT;
    end else begin
      state         <= state_n;
      timer         <= timer_n;
      lfsr          <= lfsr_n;
      mole_position <= pos_n;
      miss_count    <= miss_n;
      hit_total     <= hits_n;
      up_ticks      <= up_n;
    end
  end

  assign mole_valid = (state == UP);
  assign game_over  = (state == OVER);
  assign mole_leds  = mole_valid ? (LED_ONE << mole_position) : '0;

endmodule

// File: doc/mole_spawner.md
Name: mole_spawner

Overview:
Game-side producer for the whack-a-mole datapath. Chooses a pseudo-random hole and presents it as mole_position to the hammer detector. It consumes the detector's one-cycle hit pulse, times each mole's exposure, and counts misses. Exposure time shrinks after every hit, and the game ends after a set number of misses.

Parameters:
NUM_HOLES, 18, number of holes/switches; legal range 2..31
GAP_TICKS, 25000000, clk cycles with no mole shown between moles; must be ≥1
UP_TICKS, 50000000, initial mole exposure in clk cycles
MIN_UP_TICKS, 12500000, floor on exposure; must be ≥1 and ≤UP_TICKS
STEP_TICKS, 2500000, exposure reduction applied per accepted hit
MAX_MISSES, 5, misses that end the game; range 1..255
LFSR_SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
start  in  1  one-cycle pulse; starts the game from IDLE or OVER, ignored otherwise
hit  in  1  registered hit pulse from the hammer detector
mole_position  out  5  current hole index, 0..NUM_HOLES-1
mole_valid  out  1  high while the mole is exposed (UP state)
mole_leds  out  NUM_HOLES  one-hot of mole_position when mole_valid is high, else 0; combinational from registers
miss_count  out  8  misses this game
hit_total  out  8  accepted hits this game, saturates at 255
game_over  out  1  high in OVER state
up_ticks  out  32  current exposure length, for debug/display

Behaviour:
- Reset values: state=IDLE, mole_position=0, mole_valid=0, miss_count=0, hit_total=0, game_over=0, up_ticks=UP_TICKS, timer=0, lfsr=LFSR_SEED.
- LFSR: 16-bit Fibonacci, free-running every cycle in all states.
  - lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
- Candidate position: r=lfsr[4:0]. cand = r-NUM_HOLES if r≥NUM_HOLES, else r. If r-NUM_HOLES is still ≥NUM_HOLES, subtract again.
- Repeat avoidance: if cand==mole_position, next_pos = cand+1, wrapping to 0 at NUM_HOLES. Otherwise next_pos = cand. Consecutive moles are never in the same hole.
- States: IDLE, GAP, UP, OVER.
- IDLE:
  - start → GAP; timer=GAP_TICKS-1.
  - hit is ignored.
- GAP:
  - mole_valid=0; mole_position holds its last value.
  - Timer decrements each cycle. At timer==0 → UP on the next edge. On that same edge: mole_position=next_pos, timer=up_ticks-1, mole_valid=1.
  - hit is ignored. The detector may pulse hit on a stale position; this is not scored.
- UP:
  - If hit==1: hit_total+=1 (saturating). up_ticks = max(up_ticks-STEP_TICKS, MIN_UP_TICKS), computed without underflow. → GAP with timer=GAP_TICKS-1.
  - Else if timer==0: miss_count+=1. If the new miss_count==MAX_MISSES → OVER, otherwise → GAP with timer=GAP_TICKS-1.
  - Else timer decrements.
  - A hit in the same cycle as timer==0 counts as a hit, not a miss (hit has priority).
- OVER:
  - mole_valid=0, game_over=1. Counters hold.
  - start → clear miss_count, hit_total and game_over; up_ticks=UP_TICKS; → GAP with timer=GAP_TICKS-1.
- start is ignored in GAP and UP; no restart mid-game.
- Latency:
  - hit sampled in UP → mole_valid low on the next edge.
  - First mole appears exactly GAP_TICKS cycles after the edge that samples start.
- Reset mid-game: immediately returns all registers to reset values, including the LFSR.

Test Plan:
Params NUM_HOLES=18, GAP_TICKS=4, UP_TICKS=10, MIN_UP_TICKS=4, STEP_TICKS=3, MAX_MISSES=3, LFSR_SEED=16'hACE1.
1. Reset, then pulse start at cycle 0 → mole_valid rises at cycle 4; mole_position equals the reduced lfsr[4:0] at that edge and is <18; mole_leds is one-hot at that index.
2. No hits → each mole is up for exactly 10 cycles; miss_count steps 1,2,3; after the third miss game_over=1, state OVER, mole_valid=0.
3. Hit on the 3rd UP cycle of four consecutive moles → hit_total=4; up_ticks goes 7, 4, 4, 4; exposure measured on the following mole matches; miss_count=0.
4. Hit asserted in the same cycle the UP timer reaches 0 → hit_total+1, miss_count unchanged.
5. Hit pulses during IDLE, GAP and OVER → no counter change. A start pulse during UP → ignored. Across 200 spawned moles, no two consecutive moles share a position and all positions are <18.
6. Assert reset mid-UP → all outputs at reset values on the same cycle. Pulse start from OVER → counters cleared, up_ticks=10, first mole appears after 4 cycles.
